// File: rtl/csa_resolve_adder.sv
// Resolves a carry-save pair into one binary value, adding SEG_W bits per cycle
// with a registered carry between segments; result carries the final carry-out in bit WIDTH.
module csa_resolve_adder #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SEG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and ready/valid here are decoded from state alone.

  localparam int unsigned NUM_SEG = WIDTH / SEG_W;
  localparam int unsigned CNT_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic               cy_q, cy_d;
  logic [WIDTH:0]     result_q, result_d;

  logic [SEG_W:0]     seg_sum;
  int unsigned        seg_lsb;
  logic               last_seg;

  always_comb begin
    seg_lsb   = 32'(seg_cnt_q) * SEG_W;
    last_seg  = (seg_cnt_q == LAST_SEG);
    seg_sum   = {1'b0, a_q[seg_lsb +: SEG_W]} + {1'b0, b_q[seg_lsb +: SEG_W]}
              + {{SEG_W{1'b0}}, cy_q};

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    seg_cnt_d = seg_cnt_q;
    cy_d      = cy_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = sum_in;
          b_d       = carry_in;
          seg_cnt_d = '0;
          cy_d      = 1'b0;
          result_d  = '0;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        result_d[seg_lsb +: SEG_W] = seg_sum[SEG_W-1:0];
        cy_d = seg_sum[SEG_W];
        // The counter parks on the last segment rather than wrapping; accept reloads it.
        if (last_seg) begin
          result_d[WIDTH] = seg_sum[SEG_W];
          state_d         = S_DONE;
        end else begin
          seg_cnt_d = seg_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      seg_cnt_q <= '0;
      cy_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      seg_cnt_q <= seg_cnt_d;
      cy_q      <= cy_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_csa_resolve_adder.sv
// Bench for csa_resolve_adder: a 128/32 instance for the main scenarios and a
// 64/64 instance for the single-segment case, checked against plain wide addition.
module tb_csa_resolve_adder;

  localparam int W  = 128;
  localparam int SW = 32;
  localparam int NS = W / SW;
  localparam int W1 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  sum_in, carry_in;
  logic [W:0]    result;
  logic [1:0]    dbg_state;

  logic          in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W1-1:0] sum_in1, carry_in1;
  logic [W1:0]   result1;
  logic [1:0]    dbg_state1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  csa_resolve_adder #(.WIDTH(W), .SEG_W(SW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  csa_resolve_adder #(.WIDTH(W1), .SEG_W(W1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .sum_in(sum_in1), .carry_in(carry_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .busy(busy1), .dbg_state(dbg_state1)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Word mix biased toward all-ones / zero so long carry chains show up often.
  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'hffff_ffff;
        1:       v[i*32 +: 32] = 32'h0;
        default: v[i*32 +: 32] = $urandom();
      endcase
    end
    return v;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid  = 1'b1;
      sum_in    = rnd_operand();
      carry_in  = rnd_operand();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
        n_fail++;
        $display("FAIL reset_c%0d: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 0",
                 c, in_ready, out_valid, busy, result);
      end
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, want 1 0 0 (nothing accepted)",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_full_ripple;
    int k;
    logic [W:0] e;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = '1;
    carry_in  = W'(1);
    e         = ref_add(sum_in, carry_in);
    tick();
    in_valid = 1'b0;
    sum_in   = '0;
    carry_in = '0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != NS) begin
      n_fail++;
      $display("FAIL ripple_latency: out_valid after %0d cycles, want %0d", k, NS);
    end
    n_cmp++;
    if (result !== e) begin
      n_fail++;
      $display("FAIL ripple_result: got %h want %h", result, e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_done_one_cycle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random(input int n_pairs);
    int sent, got, guard;
    logic [W:0] e;
    sent  = 0;
    got   = 0;
    guard = 0;
    while ((sent < n_pairs || exp_q.size() > 0) && guard < n_pairs * 20) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < n_pairs) && ($urandom_range(0, 3) != 0);
      sum_in    = rnd_operand();
      carry_in  = rnd_operand();
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(sum_in, carry_in));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra_output: got %h with nothing expected", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin
            n_fail++;
            $display("FAIL random_result_%0d: got %h want %h", got, result, e);
          end
        end
        got++;
      end
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got != n_pairs || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_count: outputs=%0d pending=%0d, want %0d and 0", got, exp_q.size(), n_pairs);
    end
  endtask

  task automatic test_backpressure;
    int k;
    logic [W:0] e1, e2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = rnd_operand();
    carry_in  = rnd_operand();
    e1        = ref_add(sum_in, carry_in);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != NS) begin
      n_fail++;
      $display("FAIL bp_latency: out_valid after %0d cycles, want %0d", k, NS);
    end
    in_valid = 1'b1;
    sum_in   = rnd_operand();
    carry_in = rnd_operand();
    e2       = ref_add(sum_in, carry_in);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (result !== e1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: result=%h out_valid=%b in_ready=%b, want %h 1 0",
                 c, result, out_valid, in_ready, e1);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_accept: busy=%b, want 1", busy);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != NS || result !== e2) begin
      n_fail++;
      $display("FAIL bp_second_result: got %h after %0d cycles, want %h after %0d", result, k, e2, NS);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    int k;
    logic [W:0] e;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = rnd_operand();
    carry_in  = rnd_operand();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_inflight: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    tick();
    reset    = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    sum_in   = W'(5);
    carry_in = W'(7);
    e        = ref_add(sum_in, carry_in);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != NS || result !== e) begin
      n_fail++;
      $display("FAIL midrst_5_plus_7: got %0d after %0d cycles, want %0d after %0d", result, k, e, NS);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_single_seg;
    int k;
    logic [W1:0] e;
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    sum_in1    = '1;
    carry_in1  = '1;
    e          = {1'b0, sum_in1} + {1'b0, carry_in1};
    tick();
    in_valid1 = 1'b0;
    k = 0;
    while (out_valid1 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != 1) begin
      n_fail++;
      $display("FAIL single_latency: out_valid after %0d cycles, want 1", k);
    end
    n_cmp++;
    if (result1 !== e) begin
      n_fail++;
      $display("FAIL single_result: got %h want %h", result1, e);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    n_cmp++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: out_valid=%b in_ready=%b, want 0 1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sum_in     = '0;
    carry_in   = '0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    sum_in1    = '0;
    carry_in1  = '0;
    @(negedge clk);
    test_reset();
    test_full_ripple();
    test_random(3000);
    test_backpressure();
    test_mid_reset();
    test_single_seg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
